// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, arbiter FSM states and the bus record
// consumed by writeback and the reservation stations.
package cdb_pkg;

  localparam int CDB_NUM_REQ = 3;
  localparam int CDB_DATA_W  = 8;
  localparam int CDB_TAG_W   = 3;
  localparam int CDB_RD_W    = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } cdb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_RD_W-1:0]   rd;
    logic                  we;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_grant_sel.sv
// One-hot selector: first valid requester at or after i_ptr, wrapping modulo N.
// Tying i_ptr to zero yields fixed priority (lowest index wins).
module cdb_grant_sel #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  localparam logic [PTR_W:0] N_L = (PTR_W+1)'(N);

  logic [PTR_W:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // i_ptr < N, so one subtraction is enough to wrap
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_idx >= N_L) w_idx = w_idx - N_L;
      if (!w_found && i_valid[w_idx[PTR_W-1:0]]) begin
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-port CDB arbiter with registered bus output and halt drain FSM.
// Define CDB_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int RD_W    = CDB_RD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*RD_W-1:0]   req_rd,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      flush,
  input  logic                      halt_req,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [RD_W-1:0]           cdb_rd,
  output logic                      cdb_we,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      halt_ack
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  cdb_state_t         r_state;
  cdb_state_t         w_state_nxt;
  logic               w_run;
  logic [PTR_W-1:0]   w_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [TAG_W-1:0]   w_tag;
  logic [RD_W-1:0]    w_rd;
  logic               w_we;
  logic [DATA_W-1:0]  w_data;

  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [RD_W-1:0]    r_rd;
  logic               r_we;
  logic [DATA_W-1:0]  r_data;

  cdb_grant_sel #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_grant_sel (
    .i_valid (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  // Grants never look at the output register: the CDB cannot back-pressure
  assign req_ready = (w_run && !flush) ? w_grant : '0;
  assign w_xfer    = |req_ready;

  always_comb begin
    w_tag  = '0;
    w_rd   = '0;
    w_we   = 1'b0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        w_tag  = req_tag[i*TAG_W +: TAG_W];
        w_rd   = req_rd[i*RD_W +: RD_W];
        w_we   = req_we[i];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CDB_ARB_RR_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) w_win = PTR_W'(i);
    end
  end

  // Only completed transfers move the pointer; flushed cycles have w_xfer=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + PTR_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    halt_ack    = 1'b0;
    case (r_state)
      RUN: begin
        w_run = 1'b1;
        if (halt_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_valid) w_state_nxt = HALTED;
      end
      HALTED: begin
        halt_ack = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Output register: a flush zeroes w_xfer, which clears valid and we
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_xfer;
      r_we    <= w_xfer & w_we;
      if (w_xfer) begin
        r_tag  <= w_tag;
        r_rd   <= w_rd;
        r_data <= w_data;
      end
    end
  end

  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_rd    = r_rd;
  assign cdb_we    = r_we;
  assign cdb_data  = r_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected CDB payloads,
// a monitor pops and compares whenever cdb_valid is seen.
module tb_cdb_arbiter;

`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef logic [13:0] exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0] req_ready;
  logic [8:0] req_tag;
  logic [5:0] req_rd;
  logic [2:0] req_we;
  logic [23:0] req_data;
  logic       flush = 1'b0;
  logic       halt_req = 1'b0;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic [1:0] cdb_rd;
  logic       cdb_we;
  logic [7:0] cdb_data;
  logic       halt_ack;

  logic [2:0] u_tag [3];
  logic [1:0] u_rd  [3];
  logic       u_we  [3];
  logic [7:0] u_data[3];

  assign req_tag  = {u_tag[2], u_tag[1], u_tag[0]};
  assign req_rd   = {u_rd[2], u_rd[1], u_rd[0]};
  assign req_we   = {u_we[2], u_we[1], u_we[0]};
  assign req_data = {u_data[2], u_data[1], u_data[0]};

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_rd    (req_rd),
    .req_we    (req_we),
    .req_data  (req_data),
    .flush     (flush),
    .halt_req  (halt_req),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_rd    (cdb_rd),
    .cdb_we    (cdb_we),
    .cdb_data  (cdb_data),
    .halt_ack  (halt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_unit(input int k, input logic [2:0] tag, input logic [1:0] rd,
                          input logic we, input logic [7:0] data);
    u_tag[k]  = tag;
    u_rd[k]   = rd;
    u_we[k]   = we;
    u_data[k] = data;
  endtask

  task automatic push_unit(input int k);
    q.push_back({u_tag[k], u_rd[k], u_we[k], u_data[k]});
  endtask

  // Monitor: compare every presented CDB beat against the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (cdb_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cdb_unexpected: got tag=%0h data=%0h expected no beat", cdb_tag, cdb_data);
        end else begin
          e = q.pop_front();
          chk("cdb_payload", 32'({cdb_tag, cdb_rd, cdb_we, cdb_data}), 32'(e));
        end
      end else begin
        chk("cdb_we_idle", 32'(cdb_we), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] oh;
    int         idx;
    for (int k = 0; k < 3; k++) set_unit(k, 3'd0, 2'd0, 1'b0, 8'h00);

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_we", 32'(cdb_we), 32'd0);
    chk("rst_payload", 32'({cdb_tag, cdb_rd, cdb_data}), 32'd0);
    chk("rst_halt_ack", 32'(halt_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All three requesters held valid for four cycles
    set_unit(0, 3'd1, 2'd1, 1'b1, 8'h11);
    set_unit(1, 3'd5, 2'd2, 1'b1, 8'hA7);
    set_unit(2, 3'd6, 2'd3, 1'b1, 8'h3C);
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      idx = RR ? (c % 3) : 0;
      oh  = 3'b001 << idx;
      #1;
      chk("grant_all", 32'(req_ready), 32'(oh));
      push_unit(idx);
      @(negedge clk);
    end

    // Single requester 1: tag 5, rd 2, we 1, data A7
    req_valid = 3'b010;
    #1;
    chk("single_ready", 32'(req_ready), 32'b010);
    push_unit(1);
    @(negedge clk);
    req_valid = 3'b000;
    chk("single_valid", 32'(cdb_valid), 32'd1);
    @(negedge clk);
    chk("single_fall", 32'(cdb_valid), 32'd0);

    // Unit 0 broadcasts tag 3 without a register write
    set_unit(0, 3'd3, 2'd1, 1'b0, 8'h55);
    req_valid = 3'b001;
    #1;
    chk("we0_ready", 32'(req_ready), 32'b001);
    push_unit(0);
    @(negedge clk);
    chk("we0_valid", 32'(cdb_valid), 32'd1);
    chk("we0_we", 32'(cdb_we), 32'd0);

    // Flush kills the grant; pointer must stay where unit 0 left it
    req_valid = 3'b011;
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_we", 32'(cdb_we), 32'd0);
    #1;
    idx = RR ? 1 : 0;
    chk("post_flush_grant", 32'(req_ready), 32'(3'b001 << idx));
    push_unit(idx);
    @(negedge clk);

    // Halt pulse while unit 2 is valid
    req_valid = 3'b100;
    halt_req  = 1'b1;
    #1;
    chk("halt_grant", 32'(req_ready), 32'b100);
    push_unit(2);
    @(negedge clk);
    halt_req = 1'b0;
    chk("drain_valid", 32'(cdb_valid), 32'd1);
    #1;
    chk("drain_ready", 32'(req_ready), 32'd0);
    chk("drain_ack", 32'(halt_ack), 32'd0);
    @(negedge clk);
    chk("drain2_ack", 32'(halt_ack), 32'd0);
    chk("drain2_valid", 32'(cdb_valid), 32'd0);
    @(negedge clk);
    chk("halted_ack", 32'(halt_ack), 32'd1);
    req_valid = 3'b111;
    #1;
    chk("halted_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("halted_ready2", 32'(req_ready), 32'd0);
    chk("halted_ack2", 32'(halt_ack), 32'd1);

    // Asynchronous reset out of HALTED, then mid-transfer
    #2 rst = 1'b1;
    #1;
    chk("rst_halt_ack", 32'(halt_ack), 32'd0);
    req_valid = 3'b010;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_run_ready", 32'(req_ready), 32'b010);
    push_unit(1);
    @(negedge clk);
    req_valid = 3'b000;
    chk("mid_valid", 32'(cdb_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(cdb_valid), 32'd0);
    chk("mid_rst_we", 32'(cdb_we), 32'd0);
    chk("mid_rst_ack", 32'(halt_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Flush and halt together
    req_valid = 3'b001;
    flush     = 1'b1;
    halt_req  = 1'b1;
    #1;
    chk("fh_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    halt_req  = 1'b0;
    req_valid = 3'b000;
    chk("fh_valid", 32'(cdb_valid), 32'd0);
    chk("fh_ack0", 32'(halt_ack), 32'd0);
    @(negedge clk);
    chk("fh_ack1", 32'(halt_ack), 32'd1);

    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
